// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SB_TICK   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       busy,
  output logic       tx_done_tick
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif
  localparam logic [2:0] StStop   = 3'd4;

  localparam logic [4:0] BitLast  = 5'd15;
  localparam logic [4:0] StopLast = 5'(SB_TICK - 1);
  localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);

  logic [2:0] state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       done;

`ifdef UART_TX_PARITY_EN
  // Bits above DATA_BITS never reach the line, so they must not affect parity either.
  localparam logic [7:0] DataMask = 8'((1 << DATA_BITS) - 1);
  logic parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          shift_d  = tx_byte;
          tick_d   = 5'd0;
          bit_d    = 3'd0;
          state_d  = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d = ^(tx_byte & DataMask);
`endif
        end
      end
      StStart: begin
        if (sample_tick) begin
          if (tick_q == BitLast) begin
            tick_d  = 5'd0;
            state_d = StData;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      StData: begin
        if (sample_tick) begin
          if (tick_q == BitLast) begin
            tick_d  = 5'd0;
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (sample_tick) begin
          if (tick_q == BitLast) begin
            tick_d  = 5'd0;
            state_d = StStop;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
`endif
      StStop: begin
        if (sample_tick) begin
          if (tick_q == StopLast) begin
            state_d = StIdle;
            done    = 1'b1;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the state being entered so tx changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      tick_q  <= 5'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx           = tx_q;
  assign busy         = (state_q != StIdle);
  assign tx_done_tick = done & ~reset;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (default build): vector table, hand corner cases,
// and a randomized run against a per-tick frame model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx;
  logic       busy;
  logic       tx_done_tick;

  int  tests = 0;
  int  fails = 0;
  logic seen_done;

  localparam int FrameTicks = 16 * 9 + 16;

  uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .tx_start     (tx_start),
    .tx_byte      (tx_byte),
    .tx           (tx),
    .busy         (busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // line[i] = level of bit slot i (start..stop)
    bit         poke;
  } vec_t;

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one clock: inputs set after an edge, done sampled before the next edge.
  task automatic cyc(input logic tk, input logic st, input logic rst, input logic [7:0] b);
    sample_tick = tk;
    tx_start    = st;
    reset       = rst;
    tx_byte     = b;
    #1;
    seen_done = tx_done_tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic level(input int k, input logic [7:0] d);
    int i;
    i = k / 16;
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    return 1'b1;
  endfunction

  task automatic finish_frame(input string nm);
    int got;
    got = 0;
    for (int c = 0; c < 400 && got == 0; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      if (seen_done) got = 1;
    end
    check_int({nm, " done_reached"}, got, 1);
  endtask

  task automatic send_table(input logic [7:0] data, input logic [9:0] exp_line, input bit poke,
                            input string nm);
    logic [9:0] cap;
    int         k;
    int         done_at;
    int         extra;
    logic       tk;
    logic       st;
    cap     = '0;
    k       = 0;
    done_at = -1;
    cyc(1'b0, 1'b1, 1'b0, data);
    check_bit({nm, " start_low"}, tx, 1'b0);
    check_bit({nm, " busy_on"}, busy, 1'b1);
    for (int c = 0; c < 1000 && done_at < 0; c++) begin
      tk = c[0];
      st = poke && (k >= 30) && (k < 60);
      cyc(tk, st, 1'b0, poke ? 8'h55 : data);
      if (seen_done) done_at = k + 1;
      if (tk) k++;
      if (tk && (k % 16) == 8 && (k / 16) < 10) cap[k/16] = tx;
    end
    check_int({nm, " frame_ticks"}, done_at, FrameTicks);
    check_int({nm, " line_bits"}, int'(cap), int'(exp_line));
    check_bit({nm, " busy_after"}, busy, 1'b0);
    check_bit({nm, " tx_idle_after"}, tx, 1'b1);
    if (poke) begin
      extra = 0;
      for (int c = 0; c < 400; c++) begin
        cyc(c[0], 1'b0, 1'b0, 8'h00);
        if (seen_done || !tx || busy) extra++;
      end
      check_int({nm, " no_second_frame"}, extra, 0);
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   k;
    int   cnt;
    bit   in_frame;
    logic [7:0] mb;
    logic tk;
    logic st;
    logic [7:0] b;
    logic exp_done;

    vecs[0] = '{data: 8'hA5, line: 10'b1101001010, poke: 1'b1};
    vecs[1] = '{data: 8'h00, line: 10'b1000000000, poke: 1'b0};
    vecs[2] = '{data: 8'hFF, line: 10'b1111111110, poke: 1'b0};
    vecs[3] = '{data: 8'h3C, line: 10'b1001111000, poke: 1'b0};
    vecs[4] = '{data: 8'h81, line: 10'b1100000010, poke: 1'b0};

    // Reset and long idle
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    check_bit("reset tx", tx, 1'b1);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset done", seen_done, 1'b0);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      cyc(c[0], 1'b0, 1'b0, 8'hA5);
      if (seen_done || !tx || busy) cnt++;
    end
    check_int("idle quiet", cnt, 0);

    foreach (vecs[i]) begin
      send_table(vecs[i].data, vecs[i].line, vecs[i].poke, $sformatf("vec%0d", i));
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
    end

    // Back-to-back: request in the first idle cycle after done
    send_table(8'h3C, 10'b1001111000, 1'b0, "b2b_first");
    cyc(1'b0, 1'b1, 1'b0, 8'hC3);
    check_bit("b2b start_low", tx, 1'b0);
    check_bit("b2b busy", busy, 1'b1);
    finish_frame("b2b");

    // Reset 70 ticks into a frame, then a clean frame
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'hA5);
    for (int c = 0; c < 70; c++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    check_bit("pre_reset tx", tx, level(70, 8'hA5));
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    check_bit("midreset tx", tx, 1'b1);
    check_bit("midreset busy", busy, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    send_table(8'h81, 10'b1100000010, 1'b0, "after_reset");

    // Frozen tick: nothing moves, requests ignored
    cyc(1'b0, 1'b1, 1'b0, 8'hA5);
    for (int c = 0; c < 20; c++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      cyc(1'b0, c[0], 1'b0, 8'h00);
      if (seen_done || tx !== level(20, 8'hA5) || !busy) cnt++;
    end
    check_int("freeze hold", cnt, 0);
    finish_frame("freeze");

    // Randomized run against the frame model
    in_frame = 1'b0;
    k        = 0;
    mb       = 8'h00;
    for (int c = 0; c < 8000 && fails == 0; c++) begin
      tk = ($urandom_range(0, 1) == 1);
      st = in_frame ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      b  = 8'($urandom);
      exp_done = in_frame && (k == FrameTicks - 1) && tk;
      cyc(tk, st, 1'b0, b);
      check_bit("rand done", seen_done, exp_done);
      if (in_frame) begin
        if (tk) k++;
        if (k >= FrameTicks) in_frame = 1'b0;
      end else if (st) begin
        in_frame = 1'b1;
        k        = 0;
        mb       = b;
      end
      check_bit("rand tx", tx, in_frame ? level(k, mb) : 1'b1);
      check_bit("rand busy", busy, in_frame);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
